// File: rtl/delay_timer.sv
// Programmable trigger-to-timeout delay with prescaler and three run modes.
// Shared timing primitive for light-step intervals and the lights-out hold.
module delay_timer #(
    parameter int WIDTH = 14,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             cancel,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] N,
    input  logic [PW-1:0]    tick_div,
    output logic             time_out,
    output logic             busy,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] ONESHOT   = 2'b00;
    localparam logic [1:0] RETRIGGER = 2'b01;
    localparam logic [1:0] PERIODIC  = 2'b10;

    state_t           state;
    logic             trig_q;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] n_lat;
    logic [1:0]       mode_lat;
    logic [PW-1:0]    div_lat;
    logic [PW-1:0]    presc;

    logic             trig_edge;
    logic             tick;
    logic             expiry;
    logic             can_retrig;
    logic [WIDTH-1:0] n_eff;
    logic [1:0]       mode_eff;

    assign trig_edge  = trigger & ~trig_q;
    assign tick       = (state == RUN) && (presc == div_lat);
    assign expiry     = tick && (count == WIDTH'(1));
    assign can_retrig = (mode_lat == RETRIGGER) || (mode_lat == PERIODIC);
    assign n_eff      = (N == '0) ? WIDTH'(1) : N;
    // The unused encoding behaves as a plain one-shot.
    assign mode_eff   = (mode == 2'b11) ? ONESHOT : mode;
    // count is forced to 0 whenever the FSM leaves RUN.
    assign remaining  = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            trig_q   <= 1'b1;
            count    <= '0;
            n_lat    <= '0;
            mode_lat <= ONESHOT;
            div_lat  <= '0;
            presc    <= '0;
            time_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            trig_q   <= trigger;
            time_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig_edge && !cancel) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        count    <= n_eff;
                        n_lat    <= n_eff;
                        mode_lat <= mode_eff;
                        div_lat  <= tick_div;
                        presc    <= '0;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                        presc <= '0;
                    end else if (expiry) begin
                        time_out <= 1'b1;
                        if (trig_edge) begin
                            count    <= n_eff;
                            n_lat    <= n_eff;
                            mode_lat <= mode_eff;
                            div_lat  <= tick_div;
                            presc    <= '0;
                        end else if (mode_lat == PERIODIC) begin
                            count <= n_lat;
                            presc <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            count <= '0;
                            presc <= '0;
                        end
                    end else if (trig_edge && can_retrig) begin
                        count    <= n_eff;
                        n_lat    <= n_eff;
                        mode_lat <= mode_eff;
                        div_lat  <= tick_div;
                        presc    <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        count <= count - WIDTH'(1);
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
            endcase
        end
    end

endmodule
